// File: rtl/n64_poll_decoder.sv
// n64_poll_decoder
// Host side of the N64 controller single-wire link. Periodically sends the
// poll command, receives the 32-bit reply and maps it onto the 12-bit button
// vector used by the NES/SNES serializers, plus the raw stick bytes.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | line released, waiting for the poll timer to wrap
// TX      | sending 0x01 MSB first, then the host stop bit
// RX_WAIT | waiting for the next reply falling edge (bounded by timeout)
// RX_BIT  | 2 us after the falling edge: sample and shift one reply bit
// UPDATE  | full 32-bit reply held: register outputs, pulse frame_valid
// ERROR   | reply timed out: release buttons, pulse frame_err

module n64_poll_decoder #(
    parameter int CYCLES_PER_US  = 12,
    parameter int POLL_PERIOD_US = 16000,
    parameter int RX_TIMEOUT_US  = 100,
    parameter int STICK_THRESH   = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        n64_in,
    output logic        n64_drive_low,
    output logic [11:0] buttons_out,
    output logic [7:0]  stick_x,
    output logic [7:0]  stick_y,
    output logic        frame_valid,
    output logic        frame_err
);

    localparam int POLL_CYCLES = CYCLES_PER_US * POLL_PERIOD_US;
    localparam int POLL_W      = $clog2(POLL_CYCLES);
    localparam int US_W        = $clog2(CYCLES_PER_US * 8) + 1;
    localparam int TO_CYCLES   = CYCLES_PER_US * RX_TIMEOUT_US;
    localparam int TO_W        = $clog2(TO_CYCLES + 1);

    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);
    localparam logic [US_W-1:0]   BIT_LAST  = US_W'(4 * CYCLES_PER_US - 1);
    localparam logic [US_W-1:0]   LOW_1US   = US_W'(CYCLES_PER_US);
    localparam logic [US_W-1:0]   LOW_3US   = US_W'(3 * CYCLES_PER_US);
    localparam logic [US_W-1:0]   STOP_LAST = US_W'(CYCLES_PER_US - 1);
    localparam logic [US_W-1:0]   SAMPLE_AT = US_W'(2 * CYCLES_PER_US - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_CYCLES - 1);
    localparam logic [7:0]        POLL_CMD  = 8'h01;

    localparam logic signed [7:0] THR_POS = 8'(STICK_THRESH);
    localparam logic signed [7:0] THR_NEG = -THR_POS;

    typedef enum logic [2:0] {
        IDLE,
        TX,
        RX_WAIT,
        RX_BIT,
        UPDATE,
        ERROR
    } state_t;

    state_t             state;
    logic               sync_meta;
    logic               sync_cur;
    logic               sync_prev;
    logic               line_fall;
    logic [POLL_W-1:0]  poll_cnt;
    logic               poll_wrap;
    logic [US_W-1:0]    us_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic [3:0]         tx_bit;
    logic [US_W-1:0]    tx_low_len;
    logic [4:0]         bit_cnt;
    logic [31:0]        shift_reg;
    logic [11:0]        btn_next;
    logic signed [7:0]  axis_x;
    logic signed [7:0]  axis_y;
    logic               unused_reply_bits;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    // Reset to the idle-high level so no edge is seen right after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b1;
            sync_cur  <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync_meta <= n64_in;
            sync_cur  <= sync_meta;
            sync_prev <= sync_cur;
        end
    end

    assign line_fall = sync_prev & ~sync_cur;

    // Free-running poll timer; it never pauses, so the poll rate is exact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_cnt <= '0;
        end else if (poll_wrap) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + POLL_W'(1);
        end
    end

    assign poll_wrap  = (poll_cnt == POLL_LAST);
    assign tx_low_len = POLL_CMD[3'd7 - tx_bit[2:0]] ? LOW_1US : LOW_3US;

    // Reply decode: raw d-pad OR'd with signed stick threshold compares.
    always_comb begin
        axis_x      = shift_reg[15:8];
        axis_y      = shift_reg[7:0];
        btn_next    = '0;
        btn_next[0] = shift_reg[27] | (axis_y >= THR_POS);
        btn_next[1] = shift_reg[26] | (axis_y <= THR_NEG);
        btn_next[2] = shift_reg[25] | (axis_x <= THR_NEG);
        btn_next[3] = shift_reg[24] | (axis_x >= THR_POS);
        btn_next[4] = shift_reg[28];
        btn_next[5] = shift_reg[29];
        btn_next[6] = shift_reg[31];
        btn_next[7] = shift_reg[30];
        btn_next[8] = shift_reg[18];
        btn_next[9] = shift_reg[17];
        btn_next[10] = shift_reg[21];
        btn_next[11] = shift_reg[20];
    end

    // Reserved bits, Z-less C-up and C-right carry no serializer button.
    assign unused_reply_bits = ^{shift_reg[23:22], shift_reg[19], shift_reg[16]};

    // Protocol FSM with registered line drive and outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            n64_drive_low <= 1'b0;
            buttons_out   <= '0;
            stick_x       <= '0;
            stick_y       <= '0;
            frame_valid   <= 1'b0;
            frame_err     <= 1'b0;
            us_cnt        <= '0;
            to_cnt        <= '0;
            tx_bit        <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                IDLE: begin
                    n64_drive_low <= 1'b0;
                    if (poll_wrap) begin
                        state         <= TX;
                        tx_bit        <= '0;
                        us_cnt        <= '0;
                        n64_drive_low <= 1'b1;
                    end
                end
                TX: begin
                    if (tx_bit == 4'd8) begin
                        if (us_cnt == STOP_LAST) begin
                            n64_drive_low <= 1'b0;
                            state         <= RX_WAIT;
                            to_cnt        <= '0;
                            bit_cnt       <= '0;
                        end else begin
                            us_cnt <= us_cnt + US_W'(1);
                        end
                    end else if (us_cnt == BIT_LAST) begin
                        us_cnt        <= '0;
                        tx_bit        <= tx_bit + 4'd1;
                        n64_drive_low <= 1'b1;
                    end else begin
                        us_cnt        <= us_cnt + US_W'(1);
                        n64_drive_low <= ((us_cnt + US_W'(1)) < tx_low_len);
                    end
                end
                RX_WAIT: begin
                    // The timeout is measured from the last detected edge.
                    if (line_fall) begin
                        state  <= RX_BIT;
                        us_cnt <= '0;
                        to_cnt <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        state <= ERROR;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                RX_BIT: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    if (us_cnt == SAMPLE_AT) begin
                        shift_reg <= {shift_reg[30:0], sync_cur};
                        bit_cnt   <= bit_cnt + 5'd1;
                        state     <= (bit_cnt == 5'd31) ? UPDATE : RX_WAIT;
                    end else begin
                        us_cnt <= us_cnt + US_W'(1);
                    end
                end
                UPDATE: begin
                    buttons_out <= btn_next;
                    stick_x     <= shift_reg[15:8];
                    stick_y     <= shift_reg[7:0];
                    frame_valid <= 1'b1;
                    state       <= IDLE;
                end
                ERROR: begin
                    buttons_out   <= '0;
                    frame_err     <= 1'b1;
                    n64_drive_low <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    n64_drive_low <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_n64_poll_decoder.sv
// tb_n64_poll_decoder
// Directed bench: checks the poll timing and command waveform, decodes a set
// of hand-built controller replies, and exercises timeout, mid-frame reset
// and a glitched reply.

module tb_n64_poll_decoder;

    localparam int CPU = 4;
    localparam int PP  = 200;
    localparam int TO  = 20;
    localparam int TH  = 48;

    logic        clk;
    logic        reset;
    logic        ctrl;
    logic        n64_line;
    logic        drive_low;
    logic [11:0] buttons;
    logic [7:0]  sx;
    logic [7:0]  sy;
    logic        fv;
    logic        fe;

    int cyc        = 0;
    int total      = 0;
    int bad        = 0;
    int valid_cnt  = 0;
    int err_cnt    = 0;
    int err_cyc    = 0;
    int last_fall  = 0;
    int poll_start = 0;
    int rel_cyc    = 0;
    int tx_w[9];

    assign n64_line = drive_low ? 1'b0 : ctrl;

    n64_poll_decoder #(
        .CYCLES_PER_US (CPU),
        .POLL_PERIOD_US(PP),
        .RX_TIMEOUT_US (TO),
        .STICK_THRESH  (TH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .n64_in       (n64_line),
        .n64_drive_low(drive_low),
        .buttons_out  (buttons),
        .stick_x      (sx),
        .stick_y      (sy),
        .frame_valid  (fv),
        .frame_err    (fe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled 1 time unit after each active edge.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (fv === 1'b1) valid_cnt = valid_cnt + 1;
            if (fe === 1'b1) begin
                err_cnt = err_cnt + 1;
                err_cyc = cyc;
            end
        end
    end

    // Wait for the next poll and measure the low widths of the 9 host bits.
    task automatic wait_poll(output bit ok);
        int n;
        int w;
        int h;
        ok = 1'b0;
        n  = 0;
        while (drive_low !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (drive_low !== 1'b1) return;
        poll_start = cyc;
        for (int k = 0; k < 9; k++) begin
            w = 0;
            while (drive_low === 1'b1 && w < 100) begin
                w++;
                @(negedge clk);
            end
            tx_w[k] = w;
            if (k < 8) begin
                h = 0;
                while (drive_low === 1'b0 && h < 100) begin
                    h++;
                    @(negedge clk);
                end
            end
        end
        ok = 1'b1;
    endtask

    // Controller model: nbits reply bits MSB first, optional 1-cycle glitch
    // late in bit glitch_at (which must be a 1), optional controller stop bit.
    task automatic send_bits(input logic [31:0] data, input int nbits,
                             input int glitch_at, input bit stop);
        int lo;
        repeat (2 * CPU) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            lo        = data[31 - i] ? CPU : 3 * CPU;
            ctrl      = 1'b0;
            last_fall = cyc;
            repeat (lo) @(negedge clk);
            ctrl = 1'b1;
            if (i == glitch_at) begin
                repeat (8) @(negedge clk);
                ctrl = 1'b0;
                @(negedge clk);
                ctrl = 1'b1;
                repeat (4 * CPU - lo - 9) @(negedge clk);
            end else begin
                repeat (4 * CPU - lo) @(negedge clk);
            end
        end
        if (stop) begin
            ctrl = 1'b0;
            repeat (2 * CPU) @(negedge clk);
            ctrl = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ctrl  = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (drive_low !== 1'b0) begin bad++; $display("FAIL rst_drive got=%b want=0", drive_low); end
        total++; if (buttons !== 12'h000) begin bad++; $display("FAIL rst_buttons got=%h want=000", buttons); end
        total++; if (sx !== 8'h00) begin bad++; $display("FAIL rst_stick_x got=%h want=00", sx); end
        total++; if (sy !== 8'h00) begin bad++; $display("FAIL rst_stick_y got=%h want=00", sy); end
        total++; if (fv !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", fv); end
        total++; if (fe !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", fe); end
        reset   = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic test_first_poll();
        bit ok;
        int v0;
        int e0;
        int n;
        int want;
        v0 = valid_cnt;
        e0 = err_cnt;
        wait_poll(ok);
        total++; if (!ok) begin bad++; $display("FAIL first_poll_seen got=none want=poll"); end
        total++; if (poll_start - rel_cyc != 800) begin bad++; $display("FAIL first_poll_cycle got=%0d want=800", poll_start - rel_cyc); end
        for (int k = 0; k < 9; k++) begin
            want = (k < 7) ? 3 * CPU : CPU;
            total++;
            if (tx_w[k] != want) begin bad++; $display("FAIL tx_low_width bit=%0d got=%0d want=%0d", k, tx_w[k], want); end
        end
        send_bits(32'h8010_0000, 32, -1, 1'b1);
        n = 0;
        while (valid_cnt == v0 && err_cnt == e0 && n < 300) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL ar_valid_pulses got=%0d want=1", valid_cnt - v0); end
        total++; if (err_cnt != e0) begin bad++; $display("FAIL ar_err_pulses got=%0d want=0", err_cnt - e0); end
        total++; if (buttons !== 12'h840) begin bad++; $display("FAIL ar_buttons got=%h want=840", buttons); end
        total++; if (sx !== 8'h00 || sy !== 8'h00) begin bad++; $display("FAIL ar_sticks got=%h/%h want=00/00", sx, sy); end
    endtask

    task automatic test_frame(input string name, input logic [31:0] data,
                              input logic [11:0] exp_btn, input logic [7:0] exp_x,
                              input logic [7:0] exp_y);
        bit ok;
        int v0;
        int e0;
        int n;
        v0 = valid_cnt;
        e0 = err_cnt;
        wait_poll(ok);
        total++; if (!ok) begin bad++; $display("FAIL %s_poll got=none want=poll", name); end
        send_bits(data, 32, -1, 1'b1);
        n = 0;
        while (valid_cnt == v0 && err_cnt == e0 && n < 300) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL %s_valid got=%0d want=1", name, valid_cnt - v0); end
        total++; if (err_cnt != e0) begin bad++; $display("FAIL %s_err got=%0d want=0", name, err_cnt - e0); end
        total++; if (buttons !== exp_btn) begin bad++; $display("FAIL %s_buttons got=%h want=%h", name, buttons, exp_btn); end
        total++; if (sx !== exp_x) begin bad++; $display("FAIL %s_stick_x got=%h want=%h", name, sx, exp_x); end
        total++; if (sy !== exp_y) begin bad++; $display("FAIL %s_stick_y got=%h want=%h", name, sy, exp_y); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int v0;
        int e0;
        wait_poll(ok);
        total++; if (!ok) begin bad++; $display("FAIL midrst_poll got=none want=poll"); end
        send_bits(32'hFFFF_0000, 10, -1, 1'b0);
        ctrl = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++; if (drive_low !== 1'b0) begin bad++; $display("FAIL midrst_drive got=%b want=0", drive_low); end
        total++; if (buttons !== 12'h000) begin bad++; $display("FAIL midrst_buttons got=%h want=000", buttons); end
        total++; if (sx !== 8'h00 || sy !== 8'h00) begin bad++; $display("FAIL midrst_sticks got=%h/%h want=00/00", sx, sy); end
        total++; if (fv !== 1'b0 || fe !== 1'b0) begin bad++; $display("FAIL midrst_pulses got=%b%b want=00", fv, fe); end
        ctrl = 1'b1;
        repeat (3) @(negedge clk);
        reset   = 1'b0;
        rel_cyc = cyc;
        v0      = valid_cnt;
        e0      = err_cnt;
        wait_poll(ok);
        total++; if (poll_start - rel_cyc != 800) begin bad++; $display("FAIL midrst_next_poll got=%0d want=800", poll_start - rel_cyc); end
        total++; if (valid_cnt != v0 || err_cnt != e0) begin bad++; $display("FAIL midrst_no_pulse got=%0d/%0d want=0/0", valid_cnt - v0, err_cnt - e0); end
        // Answer this poll so the next test starts from a clean frame.
        send_bits(32'h0000_0000, 32, -1, 1'b1);
        repeat (20) @(negedge clk);
    endtask

    task automatic test_truncated();
        bit ok;
        int v0;
        int e0;
        int n;
        int p1;
        int dly;
        v0 = valid_cnt;
        e0 = err_cnt;
        wait_poll(ok);
        total++; if (!ok) begin bad++; $display("FAIL trunc_poll got=none want=poll"); end
        p1 = poll_start;
        send_bits(32'hA5A5_A5A5, 20, -1, 1'b0);
        n = 0;
        while (valid_cnt == v0 && err_cnt == e0 && n < 300) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        dly = err_cyc - last_fall;
        total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL trunc_err got=%0d want=1", err_cnt - e0); end
        total++; if (valid_cnt != v0) begin bad++; $display("FAIL trunc_valid got=%0d want=0", valid_cnt - v0); end
        // Timeout plus synchronizer and output register latency.
        total++; if (dly < TO * CPU || dly > TO * CPU + 8) begin bad++; $display("FAIL trunc_delay got=%0d want=80..88", dly); end
        total++; if (buttons !== 12'h000) begin bad++; $display("FAIL trunc_buttons got=%h want=000", buttons); end
        total++; if (sx !== 8'h30 || sy !== 8'hC0) begin bad++; $display("FAIL trunc_stick_hold got=%h/%h want=30/C0", sx, sy); end
        wait_poll(ok);
        total++; if (poll_start - p1 != 800) begin bad++; $display("FAIL trunc_next_poll got=%0d want=800", poll_start - p1); end
        v0 = valid_cnt;
        send_bits(32'h8010_0000, 32, -1, 1'b1);
        n = 0;
        while (valid_cnt == v0 && n < 300) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        total++; if (buttons !== 12'h840) begin bad++; $display("FAIL trunc_recover got=%h want=840", buttons); end
    endtask

    task automatic test_glitch();
        bit ok;
        int v0;
        int e0;
        int n;
        v0 = valid_cnt;
        e0 = err_cnt;
        wait_poll(ok);
        total++; if (!ok) begin bad++; $display("FAIL glitch_poll got=none want=poll"); end
        send_bits(32'h8010_0000, 32, 0, 1'b1);
        n = 0;
        while (valid_cnt == v0 && err_cnt == e0 && n < 300) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        total++;
        if ((valid_cnt - v0) + (err_cnt - e0) != 1) begin
            bad++;
            $display("FAIL glitch_one_outcome got=valid%0d/err%0d want=exactly_one", valid_cnt - v0, err_cnt - e0);
        end
        total++;
        if ((^{buttons, sx, sy, fv, fe, drive_low}) === 1'bx) begin
            bad++;
            $display("FAIL glitch_no_x got=%h/%h/%h want=known", buttons, sx, sy);
        end
    endtask

    initial begin
        reset = 1'b1;
        ctrl  = 1'b1;
        test_reset();
        test_first_poll();
        test_frame("dpad_stick", 32'h0800_30C0, 12'h00B, 8'h30, 8'hC0);
        test_frame("neg_thresh", 32'h7026_D02F, 12'h7B4, 8'hD0, 8'h2F);
        test_frame("extremes",   32'h0700_7F81, 12'h00E, 8'h7F, 8'h81);
        test_reset_mid_frame();
        test_frame("after_reset", 32'h0800_30C0, 12'h00B, 8'h30, 8'hC0);
        test_truncated();
        test_glitch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
